vga_sync_monitor: RTL and testbench
===================================

// Module: vga_sync_monitor
// PURPOSE
//  Receive-side checker for the VGA sync stream the painter drives. Samples hsync/vsync with the
//  pixel enable, measures line period, hsync width, lines/frame and vsync width, and declares lock
//  after consecutive conforming frames. Sits beside the painter for self-test, or on a capture input.
// PARAMETERS
//  H_TOTAL      800  required pixel ticks per line
//  H_SYNC       96   required hsync low width, pixel ticks
//  V_TOTAL      525  required lines per frame
//  V_SYNC       2    required vsync low width, lines
//  LOCK_FRAMES  2    consecutive good frames needed for lock (>=1)
//  CW           11   width of all measurement counters
// PORTS
//  clk           in   1   system clock (50 MHz)
//  reset         in   1   asynchronous, active-low reset
//  pix_en        in   1   pixel-tick enable, one clk wide (25 MHz rate)
//  hsync         in   1   horizontal sync, active low, asynchronous to clk
//  vsync         in   1   vertical sync, active low, asynchronous to clk
//  locked        out  1   timing conforms
//  h_period      out  CW  last measured line period, pixel ticks
//  v_lines       out  CW  last measured lines per frame
//  frame_err     out  1   one-clk pulse: bad frame or sync loss
//  err_count     out  8   saturating bad-frame count (VGA_MON_STATS_EN only)
// BEHAVIOUR
//  - Reset: locked=0, h_period=0, v_lines=0, frame_err=0, err_count=0, FSM=SEARCH, counters 0.
//  - hsync/vsync pass a 2-flop synchronizer and edge detect; internal latency from pin edge = 3 clk.
//  - hcnt increments on each pix_en and clears on the hsync falling edge; h_period <= hcnt+1 there.
//  - hwid counts pix_en while hsync is low and is checked against H_SYNC on the rising edge.
//  - vcnt increments on each hsync fall. On vsync fall, v_lines <= vcnt and vcnt clears.
//  - vwid counts hsync falls while vsync is low and is checked against V_SYNC on the vsync rise.
//  - Counters saturate at 2^CW-1. A saturated value is always a mismatch.
//  - line_bad is sticky per frame: set by any h_period!=H_TOTAL or hwid!=H_SYNC. It clears when the
//    frame is evaluated.
//  - A frame is good iff !line_bad, v_lines==V_TOTAL and the preceding vwid==V_SYNC.
//  - Same-clk hsync fall and vsync fall: the line is counted into the ending frame first, then the
//    frame is evaluated.
//  - FSM SEARCH: ignore the partial frame, wait for a vsync fall -> MEASURE with good_cnt=0.
//  - FSM MEASURE: at each vsync fall evaluate the frame.
//    - Good frame: good_cnt++. On reaching LOCK_FRAMES -> LOCKED and locked=1 on the same edge.
//    - Bad frame: good_cnt=0, pulse frame_err.
//  - FSM LOCKED: a bad frame pulses frame_err, sets locked=0 and moves to MEASURE.
//  - Timeout, any state: no hsync fall for 2*H_TOTAL pix_en ticks -> SEARCH, locked=0. frame_err
//    pulses once, and only if the FSM was not already in SEARCH.
//  - pix_en low: no counter changes, but edges are still detected and qualified on the next pix_en.
//  - Reset asserted mid-frame: all state clears immediately. After release, the first partial frame
//    is discarded (SEARCH).
// CONFIGURATION
//  VGA_MON_STATS_EN defined: err_count increments on every frame_err pulse and saturates at 255.
//  VGA_MON_STATS_EN undefined: err_count is tied to 8'd0 and no counter is synthesized.
// STRUCTURE
//  - Shared package vga_mon_pkg holds:
//    - state encoding SEARCH/MEASURE/LOCKED (2-bit localparams);
//    - 640x480@60 constants H_TOTAL=800, H_SYNC=96, V_TOTAL=525, V_SYNC=2, reused by the painter.
//  - One sub-module, sync_edge_det: 2-flop synchronizer plus registered fall/rise pulses. It is
//    instantiated twice, once for hsync and once for vsync.
// TESTING
//  1. Nominal 640x480 stream, 3 frames -> locked rises at the vsync fall ending the 2nd full frame,
//     h_period=800, v_lines=525, no frame_err.
//  2. While locked, one line of 799 ticks -> one frame_err pulse at the next vsync fall, locked=0,
//     relock 2 frames later.
//  3. hsync held high for 1600 pix_en -> frame_err pulse, locked=0, FSM=SEARCH; normal stream
//     relocks after the discard frame plus 2 good frames.
//  4. vsync width 3 lines, otherwise nominal -> that frame bad, frame_err pulse, good_cnt restarts.
//  5. reset low mid-frame for 5 clk -> all outputs 0; first post-reset partial frame produces no
//     frame_err.
//  6. VGA_MON_STATS_EN defined, 300 bad frames -> err_count=255. Macro undefined -> err_count
//     stays 0.

Source files
------------

// File: rtl/vga_mon_pkg.sv
// Shared VGA timing constants and monitor state encoding, also used by the painter.
// Latency: n/a. Backpressure: n/a.
package vga_mon_pkg;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    typedef enum logic [1:0] {
        SEARCH  = ST_SEARCH,
        MEASURE = ST_MEASURE,
        LOCKED  = ST_LOCKED
    } mon_state_t;

    // 640x480@60 timing
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_V_TOTAL = 525;
    localparam int VGA_V_SYNC  = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with registered fall/rise pulses for an idle-high async input.
// Latency: 3 clk from pin edge to pulse. Backpressure: none.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            fall <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            fall <= s3 & ~s2;
            rise <= ~s3 & s2;
        end
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// Checks hsync/vsync timing against VGA parameters and declares lock after good frames.
// Latency: 3 clk pin-to-event plus wait for pix_en. Backpressure: none. VGA_MON_STATS_EN adds err_count.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          hsync,
    input  logic          vsync,
    output logic          locked,
    output logic [CW-1:0] h_period,
    output logic [CW-1:0] v_lines,
    output logic          frame_err,
    output logic [7:0]    err_count
);

    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] H_TOT_C = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_SYN_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_TOT_C = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_SYN_C = CW'(V_SYNC);
    localparam int TO_TICKS = 2 * H_TOTAL;
    localparam int TW       = $clog2(TO_TICKS + 1);
    localparam int GW       = $clog2(LOCK_FRAMES + 1);

    logic h_fall, h_rise, v_fall, v_rise;
    logic hf_pend, hr_pend, vf_pend, vr_pend;
    logic hf_evt, hr_evt, vf_evt, vr_evt;

    sync_edge_det u_hs (.clk(clk), .rst_n(reset), .din(hsync), .fall(h_fall), .rise(h_rise));
    sync_edge_det u_vs (.clk(clk), .rst_n(reset), .din(vsync), .fall(v_fall), .rise(v_rise));

    // Edges seen between pixel ticks are held until the next pix_en.
    assign hf_evt = pix_en & (hf_pend | h_fall);
    assign hr_evt = pix_en & (hr_pend | h_rise);
    assign vf_evt = pix_en & (vf_pend | v_fall);
    assign vr_evt = pix_en & (vr_pend | v_rise);

    logic [CW-1:0] hcnt, hwid, vcnt, vwid;
    logic [CW-1:0] h_meas, v_meas;
    logic [TW-1:0] tcnt;
    logic          h_low, v_low, line_bad, vs_ok;
    logic          h_bad_now, frame_good, timeout;

    mon_state_t    state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic          err_nxt;

    assign h_meas = (hcnt == CMAX) ? CMAX : hcnt + 1'b1;
    // A line ending on the same tick as the frame belongs to the ending frame.
    assign v_meas = (hf_evt && vcnt != CMAX) ? vcnt + 1'b1 : vcnt;

    assign h_bad_now  = (hf_evt && (h_meas != H_TOT_C || h_meas == CMAX)) ||
                        (hr_evt && h_low && (hwid != H_SYN_C || hwid == CMAX));
    assign frame_good = !(line_bad || h_bad_now) && v_meas == V_TOT_C && v_meas != CMAX && vs_ok;
    assign timeout    = pix_en && !hf_evt && tcnt == TW'(TO_TICKS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hf_pend  <= 1'b0;
            hr_pend  <= 1'b0;
            vf_pend  <= 1'b0;
            vr_pend  <= 1'b0;
            hcnt     <= '0;
            hwid     <= '0;
            vcnt     <= '0;
            vwid     <= '0;
            tcnt     <= '0;
            h_low    <= 1'b0;
            v_low    <= 1'b0;
            line_bad <= 1'b0;
            vs_ok    <= 1'b0;
            h_period <= '0;
            v_lines  <= '0;
        end else begin
            hf_pend <= ~pix_en & (hf_pend | h_fall);
            hr_pend <= ~pix_en & (hr_pend | h_rise);
            vf_pend <= ~pix_en & (vf_pend | v_fall);
            vr_pend <= ~pix_en & (vr_pend | v_rise);

            if (hf_evt) begin
                hcnt     <= '0;
                h_period <= h_meas;
            end else if (pix_en && hcnt != CMAX) begin
                hcnt <= hcnt + 1'b1;
            end

            if (hf_evt) begin
                h_low <= 1'b1;
                hwid  <= CW'(1);
            end else if (hr_evt) begin
                h_low <= 1'b0;
            end else if (pix_en && h_low && hwid != CMAX) begin
                hwid <= hwid + 1'b1;
            end

            if (vf_evt) begin
                v_lines <= v_meas;
                vcnt    <= '0;
            end else if (hf_evt && vcnt != CMAX) begin
                vcnt <= vcnt + 1'b1;
            end

            if (vf_evt) begin
                v_low <= 1'b1;
                vwid  <= hf_evt ? CW'(1) : '0;
                vs_ok <= 1'b0;
            end else if (vr_evt) begin
                v_low <= 1'b0;
                vs_ok <= v_low && vwid == V_SYN_C && vwid != CMAX;
            end else if (hf_evt && v_low && vwid != CMAX) begin
                vwid <= vwid + 1'b1;
            end

            if (vf_evt)
                line_bad <= 1'b0;
            else if (h_bad_now)
                line_bad <= 1'b1;

            if (hf_evt)
                tcnt <= '0;
            else if (pix_en && tcnt != TW'(TO_TICKS))
                tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            err_nxt   = (state != SEARCH);
        end else if (vf_evt) begin
            case (state)
                SEARCH: begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                end
                MEASURE: begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 1'b1;
                        if (good_cnt == GW'(LOCK_FRAMES - 1))
                            state_nxt = LOCKED;
                    end else begin
                        good_nxt = '0;
                        err_nxt  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_nxt = MEASURE;
                        good_nxt  = '0;
                        err_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

`ifdef VGA_MON_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= 8'd0;
        else if (frame_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster (16 ticks x 6 lines).
module tb_vga_sync_monitor;

    localparam int H  = 16;
    localparam int HS = 3;
    localparam int V  = 6;
    localparam int VS = 2;
    localparam int LF = 2;
    localparam int CW = 11;
`ifdef VGA_MON_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pix_en = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic          locked;
    logic [CW-1:0] h_period;
    logic [CW-1:0] v_lines;
    logic          frame_err;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;
    int n_pulse = 0;

    vga_sync_monitor #(
        .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V), .V_SYNC(VS), .LOCK_FRAMES(LF), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .locked(locked), .h_period(h_period), .v_lines(v_lines),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) n_pulse++;

    task automatic tick();
        pix_en = 1'b1; @(posedge clk); #1;
        pix_en = 1'b0; @(posedge clk); #1;
    endtask

    task automatic send_line(input int period, input int hw, input bit vf, input bit vr);
        hsync = 1'b0;
        if (vf) vsync = 1'b0;
        if (vr) vsync = 1'b1;
        for (int i = 0; i < period; i++) begin
            if (i == hw) hsync = 1'b1;
            tick();
        end
    endtask

    task automatic send_frame(input int lines, input int vs_w, input int bad_line,
                              input int bad_period, input int bad_hw);
        for (int l = 0; l < lines; l++)
            send_line((l == bad_line) ? bad_period : H, (l == bad_line) ? bad_hw : HS,
                      l == 0, l == vs_w);
    endtask

    task automatic nominal_frame();
        send_frame(V, VS, -1, H, HS);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (h_period !== 11'd0) begin errors++; $display("FAIL reset_h_period got %0d want 0", h_period); end
        checks++; if (v_lines !== 11'd0) begin errors++; $display("FAIL reset_v_lines got %0d want 0", v_lines); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        reset = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_nominal();
        nominal_frame();
        nominal_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL nom_locked_early got %b want 0", locked); end
        nominal_frame();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL nom_locked got %b want 1", locked); end
        checks++; if (h_period !== 11'd16) begin errors++; $display("FAIL nom_h_period got %0d want 16", h_period); end
        checks++; if (v_lines !== 11'd6) begin errors++; $display("FAIL nom_v_lines got %0d want 6", v_lines); end
        checks++; if (n_pulse !== 0) begin errors++; $display("FAIL nom_no_err got %0d pulses want 0", n_pulse); end
    endtask

    // Bad frame while locked, then two good frames to relock.
    task automatic bad_then_relock(input string name, input int p0);
        nominal_frame();
        checks++; if (n_pulse !== p0 + 1) begin errors++; $display("FAIL %s_pulse got %0d want %0d", name, n_pulse, p0 + 1); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s_unlock got %b want 0", name, locked); end
        nominal_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s_one_good got %b want 0", name, locked); end
        nominal_frame();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL %s_relock got %b want 1", name, locked); end
    endtask

    task automatic test_short_line();
        int p0;
        p0 = n_pulse;
        send_frame(V, VS, 3, H - 1, HS);
        bad_then_relock("short_line", p0);
    endtask

    task automatic test_hsync_width();
        int p0;
        p0 = n_pulse;
        send_frame(V, VS, 2, H, HS + 1);
        bad_then_relock("hsync_width", p0);
    endtask

    task automatic test_timeout();
        int p0;
        p0 = n_pulse;
        repeat (3 * H) tick();
        checks++; if (n_pulse !== p0 + 1) begin errors++; $display("FAIL timeout_pulse got %0d want %0d", n_pulse, p0 + 1); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked got %b want 0", locked); end
        repeat (3 * H) tick();
        checks++; if (n_pulse !== p0 + 1) begin errors++; $display("FAIL timeout_search_quiet got %0d want %0d", n_pulse, p0 + 1); end
        nominal_frame();
        nominal_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_early_lock got %b want 0", locked); end
        nominal_frame();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_relock got %b want 1", locked); end
    endtask

    task automatic test_vsync_width();
        int p0;
        p0 = n_pulse;
        send_frame(V, VS + 1, -1, H, HS);
        bad_then_relock("vsync_width", p0);
        checks++; if (err_count !== 8'(STATS * 4)) begin errors++; $display("FAIL vsync_err_count got %0d want %0d", err_count, STATS * 4); end
    endtask

    task automatic test_reset_mid();
        int p0;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_locked got %b want 1", locked); end
        for (int l = 0; l < 3; l++) send_line(H, HS, l == 0, l == VS);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_reset_locked got %b want 0", locked); end
        checks++; if (h_period !== 11'd0) begin errors++; $display("FAIL mid_reset_h_period got %0d want 0", h_period); end
        checks++; if (v_lines !== 11'd0) begin errors++; $display("FAIL mid_reset_v_lines got %0d want 0", v_lines); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_reset_err_count got %0d want 0", err_count); end
        reset = 1'b1;
        p0 = n_pulse;
        for (int l = 3; l < V; l++) send_line(H, HS, 1'b0, 1'b0);
        nominal_frame();
        nominal_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_reset_early got %b want 0", locked); end
        nominal_frame();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_lock got %b want 1", locked); end
        checks++; if (n_pulse !== p0) begin errors++; $display("FAIL post_reset_no_err got %0d want %0d", n_pulse, p0); end
    endtask

    task automatic test_err_saturate();
        int p0;
        p0 = n_pulse;
        repeat (300) send_frame(2, 1, -1, H, HS);
        nominal_frame();
        checks++; if (n_pulse !== p0 + 300) begin errors++; $display("FAIL sat_pulses got %0d want %0d", n_pulse, p0 + 300); end
        checks++; if (err_count !== 8'(STATS * 255)) begin errors++; $display("FAIL sat_err_count got %0d want %0d", err_count, STATS * 255); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sat_locked got %b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_hsync_width();
        test_timeout();
        test_vsync_width();
        test_reset_mid();
        test_err_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
